// File: rtl/sparse_match_scheduler_if.sv
// Match output stream from the sparse match scheduler to the MAC address generator.
// Carries one matched bit address plus its sub-chunk index per valid/ready handshake.
interface sparse_match_scheduler_if #(
  parameter int unsigned W       = 32,
  parameter int unsigned MAX_SUB = 8
);
  localparam int unsigned SW = $clog2(MAX_SUB);
  localparam int unsigned AW = $clog2(W);

  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_sub;
  logic          m_last;

  modport master (
    output m_valid,
    output m_addr,
    output m_sub,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_addr,
    input  m_sub,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/sparse_match_scheduler.sv
// Sequences the AND/priority-encoder datapath across the sub-chunks of one chunk and
// registers each match into a valid/ready stream, reporting the match count at the end.
module sparse_match_scheduler #(
  parameter int unsigned W       = 32,
  parameter int unsigned MAX_SUB = 8,
  localparam int unsigned SW     = $clog2(MAX_SUB),
  localparam int unsigned AW     = $clog2(W),
  localparam int unsigned CW     = $clog2(MAX_SUB * W + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [SW:0]   sub_num_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] match_cnt_o,
  output logic [SW-1:0] sub_idx_o,
  output logic          pe_valid_o,
  output logic          pe_sub_start_o,
  input  logic          pe_valid_i,
  input  logic [AW-1:0] pe_addr_i,
  input  logic          pe_last_i,
  sparse_match_scheduler_if.master m
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e        state_q;
  logic [SW:0]   sub_num_q;
  logic [SW-1:0] sub_idx_q;
  logic          first_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] match_cnt_q;
  logic          m_valid_q;
  logic [AW-1:0] m_addr_q;
  logic [SW-1:0] m_sub_q;
  logic          m_last_q;

  logic          adv;
  logic          load;
  logic          final_sub;
  logic [SW:0]   sub_last;

  // Holding pe_valid_o low freezes the encoder, so a full output register stalls losslessly.
  always_comb begin
    pe_valid_o     = (state_q == StRun) & (~m_valid_q | m.m_ready);
    pe_sub_start_o = pe_valid_o & first_q;
    adv            = pe_valid_o & pe_last_i;
    load           = pe_valid_o & pe_valid_i;
    sub_last       = sub_num_q - (SW + 1)'(1);
    final_sub      = ({1'b0, sub_idx_q} == sub_last);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sub_num_q   <= '0;
      sub_idx_q   <= '0;
      first_q     <= 1'b0;
      cnt_q       <= '0;
      match_cnt_q <= '0;
      m_valid_q   <= 1'b0;
      m_addr_q    <= '0;
      m_sub_q     <= '0;
      m_last_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            sub_num_q <= sub_num_i;
            sub_idx_q <= '0;
            cnt_q     <= '0;
            first_q   <= 1'b1;
            if (sub_num_i == '0) begin
              state_q     <= StDone;
              match_cnt_q <= '0;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (adv) begin
            first_q <= 1'b1;
            if (final_sub) state_q <= StDrain;
            else           sub_idx_q <= sub_idx_q + SW'(1);
          end else if (pe_valid_o) begin
            first_q <= 1'b0;
          end
          if (load) cnt_q <= cnt_q + CW'(1);
        end
        StDrain: begin
          if (!m_valid_q || m.m_ready) begin
            state_q     <= StDone;
            match_cnt_q <= cnt_q;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // A load in the same cycle as a handshake replaces the register contents.
      if (load) begin
        m_valid_q <= 1'b1;
        m_addr_q  <= pe_addr_i;
        m_sub_q   <= sub_idx_q;
        m_last_q  <= adv & final_sub;
      end else if (m.m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign match_cnt_o = match_cnt_q;
  assign sub_idx_o   = sub_idx_q;
  assign m.m_valid   = m_valid_q;
  assign m.m_addr    = m_addr_q;
  assign m.m_sub     = m_sub_q;
  assign m.m_last    = m_last_q;

endmodule

// File: tb/tb_sparse_match_scheduler.sv
// Bench for sparse_match_scheduler: a behavioural priority encoder feeds the DUT and a
// match list built from the bitmaps scores the output stream, count and done timing.
module tb_sparse_match_scheduler;
  localparam int unsigned W       = 32;
  localparam int unsigned MAX_SUB = 8;
  localparam int unsigned SW      = $clog2(MAX_SUB);
  localparam int unsigned AW      = $clog2(W);
  localparam int unsigned CW      = $clog2(MAX_SUB * W + 1);

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [SW:0]   sub_num_i;
  logic          busy_o, done_o;
  logic [CW-1:0] match_cnt_o;
  logic [SW-1:0] sub_idx_o;
  logic          pe_valid_o, pe_sub_start_o;
  logic          pe_valid_i, pe_last_i;
  logic [AW-1:0] pe_addr_i;

  sparse_match_scheduler_if #(.W(W), .MAX_SUB(MAX_SUB)) m_if ();

  sparse_match_scheduler #(.W(W), .MAX_SUB(MAX_SUB)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .sub_num_i      (sub_num_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .match_cnt_o    (match_cnt_o),
    .sub_idx_o      (sub_idx_o),
    .pe_valid_o     (pe_valid_o),
    .pe_sub_start_o (pe_sub_start_o),
    .pe_valid_i     (pe_valid_i),
    .pe_addr_i      (pe_addr_i),
    .pe_last_i      (pe_last_i),
    .m              (m_if)
  );

  always #5 clk = ~clk;

  // Behavioural encoder: the AND result of each sub-chunk, consumed lowest bit first.
  logic [W-1:0] bmp [MAX_SUB];
  logic [W-1:0] enc_cur, enc_rem;

  always_comb begin
    enc_cur    = pe_sub_start_o ? bmp[sub_idx_o] : enc_rem;
    pe_valid_i = |enc_cur;
    pe_last_i  = ((enc_cur & (enc_cur - W'(1))) == '0);
    pe_addr_i  = '0;
    for (int b = W - 1; b >= 0; b--) if (enc_cur[b]) pe_addr_i = AW'(b);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)         enc_rem <= '0;
    else if (pe_valid_o) enc_rem <= enc_cur & (enc_cur - W'(1));
  end

  typedef struct {
    int addr;
    int sub;
    bit last;
  } match_t;

  match_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"},     busy_o,         0);
    check_eq({tag, "_done"},     done_o,         0);
    check_eq({tag, "_cnt"},      match_cnt_o,    0);
    check_eq({tag, "_sub_idx"},  sub_idx_o,      0);
    check_eq({tag, "_pe_valid"}, pe_valid_o,     0);
    check_eq({tag, "_pe_start"}, pe_sub_start_o, 0);
    check_eq({tag, "_m_valid"},  m_if.m_valid,   0);
    check_eq({tag, "_m_addr"},   m_if.m_addr,    0);
    check_eq({tag, "_m_sub"},    m_if.m_sub,     0);
    check_eq({tag, "_m_last"},   m_if.m_last,    0);
  endtask

  // Expected stream: every set bit in sub-chunk order; last only on the final sub-chunk's top bit.
  task automatic build_expect(input int n, output int total, output int steps);
    total = 0;
    steps = 0;
    exp_q.delete();
    for (int s = 0; s < n; s++) begin
      if (bmp[s] == '0) steps++;
      for (int b = 0; b < W; b++) begin
        if (bmp[s][b]) begin
          exp_q.push_back('{addr: b, sub: s, last: 1'b0});
          total++;
          steps++;
        end
      end
    end
    if (n > 0 && bmp[n-1] != '0) exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low in cycles 2..6.
  task automatic run_chunk(input string tag, input int n, input int mode, input bit poke);
    int total, steps, starts, done_cyc;
    bit stalled;
    logic [AW-1:0] p_addr;
    logic [SW-1:0] p_sub;
    logic          p_last;
    match_t e;
    build_expect(n, total, steps);
    starts   = 0;
    done_cyc = 0;
    stalled  = 1'b0;
    p_addr   = '0;
    p_sub    = '0;
    p_last   = 1'b0;
    @(posedge clk); #1;
    start_i   = 1'b1;
    sub_num_i = (SW + 1)'(n);
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c <= 4000 && done_cyc == 0; c++) begin
      case (mode)
        0:       m_if.m_ready = 1'b1;
        1:       m_if.m_ready = 1'($urandom_range(0, 1));
        default: m_if.m_ready = !(c >= 2 && c <= 6);
      endcase
      start_i = poke && c == 2;
      @(negedge clk);
      if (c == 1 && n > 0) begin
        check_eq({tag, "_c1_busy"},     busy_o,         1);
        check_eq({tag, "_c1_pe_valid"}, pe_valid_o,     1);
        check_eq({tag, "_c1_pe_start"}, pe_sub_start_o, 1);
        check_eq({tag, "_c1_sub_idx"},  sub_idx_o,      0);
      end
      if (stalled) begin
        check_eq({tag, "_hold_valid"}, m_if.m_valid, 1);
        check_eq({tag, "_hold_addr"},  m_if.m_addr,  p_addr);
        check_eq({tag, "_hold_sub"},   m_if.m_sub,   p_sub);
        check_eq({tag, "_hold_last"},  m_if.m_last,  p_last);
      end
      if (m_if.m_valid && !m_if.m_ready) check_eq({tag, "_bp_pe_valid"}, pe_valid_o, 0);
      if (pe_sub_start_o) begin
        check_eq({tag, "_start_idx"}, sub_idx_o, starts);
        starts++;
      end
      if (m_if.m_valid && m_if.m_ready) begin
        check_eq({tag, "_match_expected"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq({tag, "_addr"}, m_if.m_addr, e.addr);
          check_eq({tag, "_sub"},  m_if.m_sub,  e.sub);
          check_eq({tag, "_last"}, m_if.m_last, e.last);
        end
      end
      stalled = m_if.m_valid && !m_if.m_ready;
      p_addr  = m_if.m_addr;
      p_sub   = m_if.m_sub;
      p_last  = m_if.m_last;
      if (done_o) begin
        done_cyc = c;
        check_eq({tag, "_done_busy"}, busy_o,      1);
        check_eq({tag, "_done_cnt"},  match_cnt_o, total);
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    check_eq({tag, "_done_seen"}, done_cyc != 0, 1);
    check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
    check_eq({tag, "_sub_starts"}, starts, n);
    if (mode == 0) check_eq({tag, "_done_cycle"}, done_cyc, (n == 0) ? 1 : steps + 2);
    check_eq({tag, "_done_pulse"}, done_o, 0);
    check_eq({tag, "_idle_busy"}, busy_o, 0);
    check_eq({tag, "_cnt_held"}, match_cnt_o, total);
  endtask

  initial begin
    int n, kind;
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    sub_num_i    = '0;
    m_if.m_ready = 1'b1;
    for (int s = 0; s < MAX_SUB; s++) bmp[s] = '0;
    #12;
    check_quiet("reset");
    @(negedge clk);
    rst_ni = 1'b1;

    bmp[0] = 32'h0000_00F0 & 32'h0000_0030;
    run_chunk("basic", 1, 0, 1'b0);

    bmp[0] = 32'h0000_0001;
    bmp[1] = 32'h0;
    bmp[2] = 32'h8000_0000;
    run_chunk("empty_mid", 3, 0, 1'b0);

    bmp[0] = 32'h0000_000F;
    run_chunk("backpressure", 1, 2, 1'b0);

    run_chunk("zero_sub", 0, 0, 1'b0);

    bmp[0] = 32'h0000_0300;
    bmp[1] = 32'h0001_0000;
    run_chunk("ignore_start", 2, 0, 1'b1);

    // Abort mid-chunk with reset dropped between clock edges.
    bmp[0] = 32'hFFFF_FFFF;
    bmp[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start_i   = 1'b1;
    sub_num_i = (SW + 1)'(2);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (6) begin
      m_if.m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    #2;
    rst_ni = 1'b0;
    #1;
    check_quiet("abort");
    @(negedge clk);
    rst_ni       = 1'b1;
    m_if.m_ready = 1'b1;
    bmp[0] = 32'h0000_0006;
    bmp[1] = 32'h0;
    run_chunk("after_abort", 2, 0, 1'b0);

    for (int s = 0; s < MAX_SUB; s++) bmp[s] = '1;
    run_chunk("all_ones", MAX_SUB, 0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, MAX_SUB);
      for (int s = 0; s < MAX_SUB; s++) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0:       bmp[s] = '0;
          1:       bmp[s] = $urandom & $urandom & $urandom;
          2:       bmp[s] = $urandom;
          default: bmp[s] = W'(1) << $urandom_range(0, W - 1);
        endcase
      end
      run_chunk("random", n, $urandom_range(0, 1), (n > 0) && 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
